// File: rtl/if_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package if_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;
  localparam logic [31:0] NOP_INSTR        = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/pq_fifo.sv
// Synchronous FIFO of fetch entries with a single-cycle flush.
// The head entry is readable combinationally.
module pq_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// Sequential instruction prefetcher feeding the IF->ID register. Credits bound
// queued plus in-flight fetches; a redirect flushes and drops stale responses.
module if_prefetch_queue
  import if_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        PC_IFWrite,
  output logic        inst_valid,
  output logic [31:0] Instruction_if,
  output logic [31:0] PC,
  output logic [31:0] NextPC_if
);

  localparam int unsigned CW          = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIMIT = DEPTH[CW:0];

  logic [CW-1:0] count;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [31:0]   pc_hold_q;
  logic          grant, resp, push, pop;
  fetch_entry_t  head, push_entry;

  // Gating with reset keeps the request low while reset is held.
  assign imem_req  = reset && !redirect &&
                     (({1'b0, count} + {1'b0, outstanding_q}) < DEPTH_LIMIT);
  assign imem_addr = fetch_pc_q;

  assign grant = imem_req && imem_gnt;
  // A response with nothing outstanding can only be a leftover from before reset.
  assign resp  = imem_rvalid && (outstanding_q != '0);
  assign push  = resp && !redirect && (discard_q == '0);

  assign inst_valid     = (count != '0);
  assign pop            = inst_valid && PC_IFWrite && !redirect;
  assign Instruction_if = inst_valid ? head.instr : NOP_INSTR;
  assign PC             = inst_valid ? head.pc : pc_hold_q;
  assign NextPC_if      = PC + 32'd4;

  assign push_entry = '{pc: resp_pc_q, instr: imem_rdata};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(resp);
    discard_d     = discard_q;
    if (redirect) begin
      fetch_pc_d = redirect_addr;
      resp_pc_d  = redirect_addr;
      // Every fetch still in flight is stale, including ones already marked.
      discard_d  = outstanding_q - CW'(resp);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)  resp_pc_d  = resp_pc_q + 32'd4;
      if (resp && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      pc_hold_q     <= RESET_PC;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      if (inst_valid) pc_hold_q <= head.pc;
    end
  end

  pq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with an in-order variable-latency memory model.
module tb_if_prefetch_queue;
  import if_pkg::*;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        PC_IFWrite;
  logic        inst_valid;
  logic [31:0] Instruction_if;
  logic [31:0] PC;
  logic [31:0] NextPC_if;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] granted[$];
  int          lat  = 1;
  int          ncyc = 0;

  if_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect       (redirect),
    .redirect_addr  (redirect_addr),
    .PC_IFWrite     (PC_IFWrite),
    .inst_valid     (inst_valid),
    .Instruction_if (Instruction_if),
    .PC             (PC),
    .NextPC_if      (NextPC_if)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: drives responses at the falling edge, records grants 1ns later.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!reset) begin
        pend.delete();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end else if (pend.size() > 0 && pend[0].ready <= ncyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
      #1;
      if (reset && imem_req && imem_gnt) begin
        pend.push_back('{imem_addr, ncyc + lat});
        granted.push_back(imem_addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input int l);
    @(negedge clk);
    reset      = 1'b0;
    redirect   = 1'b0;
    PC_IFWrite = 1'b0;
    imem_gnt   = 1'b1;
    lat        = l;
    repeat (2) @(negedge clk);
    granted.delete();
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    redirect_addr = 32'h0;
    do_reset(1);
    #2;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b expected 0", imem_req);
    end
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid);
    end
    checks++;
    if (Instruction_if !== 32'h0) begin
      errors++; $display("FAIL reset_instr: got %h expected 0", Instruction_if);
    end
    checks++;
    if (PC !== 32'h0 || NextPC_if !== 32'h4) begin
      errors++; $display("FAIL reset_pc: got %h/%h expected 0/4", PC, NextPC_if);
    end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    do_reset(1);
    PC_IFWrite = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #2;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL stream_first_req: got %b/%h expected 1/0", imem_req, imem_addr);
    end
    @(negedge clk); #2;
    checks++;
    if (inst_valid !== 1'b0 || imem_addr !== 32'h4) begin
      errors++; $display("FAIL stream_second: got %b/%h expected 0/4", inst_valid, imem_addr);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #2;
      a = 32'(4 * k);
      checks++;
      if ({inst_valid, PC, Instruction_if, NextPC_if, imem_addr} !==
          {1'b1, a, mem_word(a), a + 32'd4, a + 32'd8}) begin
        errors++;
        $display("FAIL stream[%0d]: got v=%b pc=%h ins=%h npc=%h addr=%h expected pc=%h ins=%h",
                 k, inst_valid, PC, Instruction_if, NextPC_if, imem_addr, a, mem_word(a));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] a;
    do_reset(1);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    checks++;
    if (imem_req !== 1'b0 || granted.size() != 4) begin
      errors++; $display("FAIL stall_credit: got req=%b grants=%0d expected 0/4", imem_req, granted.size());
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= granted.size() || granted[k] !== 32'(4 * k)) begin
        errors++; $display("FAIL stall_grant[%0d]: got %h expected %h", k,
                           (k < granted.size()) ? granted[k] : 32'hx, 32'(4 * k));
      end
    end
    checks++;
    if (inst_valid !== 1'b1 || PC !== 32'h0) begin
      errors++; $display("FAIL stall_head: got %b/%h expected 1/0", inst_valid, PC);
    end
    PC_IFWrite = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #2;
      a = 32'(4 * k);
      checks++;
      if (inst_valid !== 1'b1 || PC !== a || Instruction_if !== mem_word(a)) begin
        errors++; $display("FAIL stall_pop[%0d]: got %b/%h/%h expected 1/%h/%h", k,
                           inst_valid, PC, Instruction_if, a, mem_word(a));
      end
      if (k == 1) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
          errors++; $display("FAIL stall_resume: got %b/%h expected 1/10", imem_req, imem_addr);
        end
      end
    end
  endtask

  task automatic test_redirect_stale();
    bit found = 0;
    do_reset(3);
    PC_IFWrite = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    redirect      = 1'b1;
    redirect_addr = 32'h100;
    #2;
    checks++;
    if (imem_req !== 1'b0 || granted.size() != 2) begin
      errors++; $display("FAIL stale_redir_cycle: got req=%b grants=%0d expected 0/2", imem_req, granted.size());
    end
    @(negedge clk);
    redirect = 1'b0;
    #2;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL stale_first_req: got %b/%h/v=%b expected 1/100/0", imem_req, imem_addr, inst_valid);
    end
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #2;
      if (inst_valid) begin
        found = 1;
        checks++;
        if (PC !== 32'h100 || Instruction_if !== mem_word(32'h100)) begin
          errors++; $display("FAIL stale_head: got %h/%h expected 100/%h", PC, Instruction_if, mem_word(32'h100));
        end
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL stale_timeout: got no valid head expected PC 100");
    end
  endtask

  task automatic test_redirect_pop();
    bit found = 0;
    do_reset(2);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    PC_IFWrite    = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 32'h200;
    #2;
    checks++;
    if (inst_valid !== 1'b1 || PC !== 32'h0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL rpop_setup: got v=%b pc=%h req=%b expected 1/0/0", inst_valid, PC, imem_req);
    end
    @(negedge clk);
    redirect = 1'b0;
    #2;
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200 || PC !== 32'h0) begin
      errors++; $display("FAIL rpop_flush: got v=%b req=%b addr=%h pc=%h expected 0/1/200/0",
                         inst_valid, imem_req, imem_addr, PC);
    end
    checks++;
    if (dut.discard_q !== 3'd1) begin
      errors++; $display("FAIL rpop_discard: got %0d expected 1", dut.discard_q);
    end
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #2;
      if (inst_valid) begin
        found = 1;
        checks++;
        if (PC !== 32'h200 || Instruction_if !== mem_word(32'h200)) begin
          errors++; $display("FAIL rpop_head: got %h/%h expected 200/%h", PC, Instruction_if, mem_word(32'h200));
        end
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL rpop_timeout: got no valid head expected PC 200");
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr[3];
    exp_addr[0] = 32'hFFFF_FFF8;
    exp_addr[1] = 32'hFFFF_FFFC;
    exp_addr[2] = 32'h0;
    do_reset(1);
    PC_IFWrite    = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 32'hFFFF_FFF8;
    @(negedge clk);
    reset = 1'b1;
    #2;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL wrap_redir: got %b expected 0", imem_req);
    end
    @(negedge clk);
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #2;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr[k]) begin
        errors++; $display("FAIL wrap_addr[%0d]: got %b/%h expected 1/%h", k, imem_req, imem_addr, exp_addr[k]);
      end
    end
    checks++;
    if (PC !== 32'hFFFF_FFF8 || NextPC_if !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_head0: got %h/%h expected FFFFFFF8/FFFFFFFC", PC, NextPC_if);
    end
    @(negedge clk); #2;
    checks++;
    if (PC !== 32'hFFFF_FFFC || NextPC_if !== 32'h0) begin
      errors++; $display("FAIL wrap_head1: got %h/%h expected FFFFFFFC/0", PC, NextPC_if);
    end
    @(negedge clk); #2;
    checks++;
    if (PC !== 32'h0 || Instruction_if !== mem_word(32'h0) || NextPC_if !== 32'h4) begin
      errors++; $display("FAIL wrap_head2: got %h/%h/%h expected 0/%h/4", PC, Instruction_if, NextPC_if, mem_word(32'h0));
    end
  endtask

  task automatic test_async_reset();
    do_reset(1);
    PC_IFWrite = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    checks++;
    if (inst_valid !== 1'b1 || PC !== 32'h8) begin
      errors++; $display("FAIL areset_pre: got %b/%h expected 1/8", inst_valid, PC);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0 || Instruction_if !== 32'h0 || PC !== 32'h0) begin
      errors++; $display("FAIL areset_async: got v=%b req=%b ins=%h pc=%h expected 0/0/0/0",
                         inst_valid, imem_req, Instruction_if, PC);
    end
    repeat (2) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #2;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL areset_refetch: got %b/%h expected 1/0", imem_req, imem_addr);
    end
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (inst_valid !== 1'b1 || PC !== 32'h0 || Instruction_if !== mem_word(32'h0)) begin
      errors++; $display("FAIL areset_head: got %b/%h/%h expected 1/0/%h", inst_valid, PC, Instruction_if, mem_word(32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stale();
    test_redirect_pop();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
